dmem_responder: RTL

- Data-memory responder (slave) for the pipelined RISC-V core's load/store port.
- Accepts one word-sized load or store request at a time over a valid/ready handshake, services it after a programmable wait-state latency, and returns read data or an error over a second valid/ready channel.
- Replaces the zero-latency data memory, so the pipeline's stall logic can be exercised against realistic memory timing.

---
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port.
// One request at a time over a valid/ready handshake. The response appears
// after LATENCY cycles and is held until the initiator takes it.
// Stores commit to the array on the accept edge.
// Loads read the array on the edge that enters the response state.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               write_q, write_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    // Decode of the address currently on the request bus.
    logic [31:0]        req_off;
    logic [31:0]        req_word;
    logic               req_err;
    logic [IDX_W-1:0]   req_idx;

    // Array port controls.
    logic               wr_en;
    logic               rd_en;
    logic [IDX_W-1:0]   rd_idx;
    logic [31:0]        mem_rdata;

    // Range and alignment check.
    // The below-base test is separate, so a wrapped offset can never pass
    // as a valid index.
    always_comb begin
        req_off  = req_addr - ADDR_BASE;
        req_word = req_off >> 2;
        req_err  = (req_addr[1:0] != 2'b00)
                 | (req_addr < ADDR_BASE)
                 | (req_word >= DEPTH_WORDS);
        req_idx  = req_word[IDX_W-1:0];
    end

    // Ready is forced low while reset is held, so nothing is accepted
    // (or written) during reset.
    assign req_ready = (state_q == S_IDLE) & ~rst;

    // Next-state logic and array port control for the request/response FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_idx  = idx_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    write_d = req_write;
                    err_d   = req_err;
                    idx_d   = req_idx;
                    // A store lands in the array on its accept edge.
                    wr_en   = req_write & ~req_err;
                    if (LATENCY == 1) begin
                        // Entering RESP now, so read using the live address.
                        state_d = S_RESP;
                        rd_en   = ~req_write;
                        rd_idx  = req_idx;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    rd_en   = ~write_q;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers: cleared immediately on reset.
    // A pending response is simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
        end
    end

    // Storage is split into one byte-wide array per lane, so each strobe
    // bit gates its own write port.
    // The read register only loads when a load enters RESP, so the returned
    // word stays stable while the response waits for rsp_ready.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_rdata_q;

            // Byte-lane write on accept; registered read on entry to RESP.
            always_ff @(posedge clk) begin
                if (wr_en && req_wstrb[gi]) begin
                    lane_mem[req_idx] <= req_wdata[8*gi +: 8];
                end
                if (rd_en) begin
                    lane_rdata_q <= lane_mem[rd_idx];
                end
            end

            assign mem_rdata[8*gi +: 8] = lane_rdata_q;
        end
    endgenerate

    // Response outputs are zero outside RESP.
    // Data is also zero for stores and for rejected addresses.
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_err   = rsp_valid & err_q;
    assign rsp_rdata = (rsp_valid && !write_q && !err_q) ? mem_rdata : 32'h0;

endmodule
